// File: rtl/music_sequencer_v3.sv
// rtl/music_sequencer_v3.sv - SRAM-driven single-voice music sequencer with tempo divider and duty-controlled speaker
//
// Fetches 16-bit instructions from external SRAM and plays notes as a square wave.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   start, stop         one-cycle control pulses
//   SRAM_A / SRAM_D     instruction address out, instruction data in
//   tone_note/octave    current note fields to the external frequency table
//   tone_period/valid   table answer: cycles per wave, hit flag (0 = rest)
//   SPEAKER             square-wave output
//   busy, done, cur_pc  status: playing, END reached, executing address
module music_sequencer_v3 #(
    parameter int CLK_HZ       = 50000000,
    parameter int DEFAULT_BPM  = 96,
    parameter int ADDR_W       = 18,
    parameter int SRAM_LAT     = 2,
    parameter int PAUSE_CYCLES = 2000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] SRAM_A,
    input  logic [15:0]       SRAM_D,
    output logic [3:0]        tone_note,
    output logic [1:0]        tone_octave,
    input  logic [31:0]       tone_period,
    input  logic              tone_valid,
    output logic              SPEAKER,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_pc
);

    // Beats per minute -> cycles per beat uses CLK_HZ*60 as the dividend.
    localparam logic [63:0] DIVIDEND64 = 64'(CLK_HZ) * 64'd60;
    localparam logic [31:0] DIVIDEND   = DIVIDEND64[31:0];
    localparam logic [31:0] DEF_CPB    = 32'(DIVIDEND64 / 64'(DEFAULT_BPM));
    localparam logic [11:0] DEF_BPM    = 12'(DEFAULT_BPM);
    localparam logic [40:0] PAUSE      = 41'(PAUSE_CYCLES);
    localparam logic [2:0]  LAT_LAST   = 3'(SRAM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_DIV, S_PLAY, S_DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [15:0]         ins;
    logic [2:0]          lat_ctr;
    logic [11:0]         bpm;
    logic [31:0]         cycles_per_beat;
    logic [5:0]          div_cnt;
    logic [11:0]         rem;
    logic [31:0]         quo;
    logic [39:0]         note_cycles;
    logic [39:0]         note_ctr;
    logic [31:0]         wave_ctr;
    logic [1:0]          vol;

    // One restoring-division step; remainder stays below bpm so 12 bits suffice.
    logic [12:0] rem_sh;
    logic        q_bit;
    logic [11:0] rem_nx;
    logic [39:0] note_prod;
    logic [39:0] note_calc;
    logic [34:0] duty;

    always_comb begin
        rem_sh    = {rem, quo[31]};
        q_bit     = (rem_sh >= {1'b0, bpm});
        rem_nx    = q_bit ? 12'(rem_sh - {1'b0, bpm}) : rem_sh[11:0];
        note_prod = 40'(cycles_per_beat) * ({36'd0, ins[11:8]} + 40'd1);
        note_calc = note_prod >> 2;
        if (note_calc == 40'd0) begin
            note_calc = 40'd1;
        end
        duty = (35'(tone_period) * ({33'd0, vol} + 35'd1)) >> 3;
    end

    assign SRAM_A = pc;
    assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_DIV)   || (state == S_PLAY);
    assign done   = (state == S_DONE);

    // The last PAUSE_CYCLES of each note are silent; a note no longer than the
    // pause never sounds at all.
    assign SPEAKER = (state == S_PLAY) && tone_valid && (tone_period != 32'd0) &&
                     ({3'd0, wave_ctr} < duty) &&
                     (({1'b0, note_ctr} + PAUSE) < {1'b0, note_cycles});

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= S_IDLE;
            pc              <= '0;
            cur_pc          <= '0;
            ins             <= '0;
            lat_ctr         <= '0;
            bpm             <= DEF_BPM;
            cycles_per_beat <= DEF_CPB;
            div_cnt         <= '0;
            rem             <= '0;
            quo             <= '0;
            note_cycles     <= '0;
            note_ctr        <= '0;
            wave_ctr        <= '0;
            vol             <= '0;
            tone_note       <= '0;
            tone_octave     <= '0;
        end else if (stop) begin
            state   <= S_IDLE;
            lat_ctr <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc              <= '0;
                        bpm             <= DEF_BPM;
                        cycles_per_beat <= DEF_CPB;
                        lat_ctr         <= '0;
                        state           <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // SRAM_A follows pc, so the address is already on the pins
                    // during the first FETCH cycle.
                    if (lat_ctr == LAT_LAST) begin
                        ins     <= SRAM_D;
                        lat_ctr <= '0;
                        state   <= S_DECODE;
                    end else begin
                        lat_ctr <= lat_ctr + 3'd1;
                    end
                end
                S_DECODE: begin
                    cur_pc <= pc;
                    if (ins[15]) begin
                        tone_note   <= ins[3:0];
                        tone_octave <= ins[5:4];
                        vol         <= ins[7:6];
                        note_cycles <= note_calc;
                        note_ctr    <= '0;
                        wave_ctr    <= '0;
                        state       <= S_PLAY;
                    end else begin
                        case (ins[14:12])
                            3'd0: state <= S_DONE;
                            3'd1: begin
                                bpm     <= (ins[11:0] == 12'd0) ? 12'd1 : ins[11:0];
                                div_cnt <= '0;
                                state   <= S_DIV;
                            end
                            3'd2: begin
                                pc    <= ADDR_W'(ins[11:0]);
                                state <= S_FETCH;
                            end
                            default: begin
                                pc    <= pc + 1'b1;
                                state <= S_FETCH;
                            end
                        endcase
                    end
                end
                S_DIV: begin
                    if (div_cnt == 6'd0) begin
                        rem     <= '0;
                        quo     <= DIVIDEND;
                        div_cnt <= 6'd1;
                    end else begin
                        rem <= rem_nx;
                        quo <= {quo[30:0], q_bit};
                        if (div_cnt == 6'd32) begin
                            cycles_per_beat <= {quo[30:0], q_bit};
                            pc              <= pc + 1'b1;
                            state           <= S_FETCH;
                        end else begin
                            div_cnt <= div_cnt + 6'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // Wrap on >= so a shorter period from the live table is
                    // honoured at once instead of counting up to 2^32.
                    if (({1'b0, wave_ctr} + 33'd1) >= {1'b0, tone_period}) begin
                        wave_ctr <= '0;
                    end else begin
                        wave_ctr <= wave_ctr + 32'd1;
                    end
                    if (note_ctr == note_cycles - 40'd1) begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end else begin
                        note_ctr <= note_ctr + 40'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
